// File: rtl/pvt_meter_pkg.sv
// Shared types and constants for the PVT monitor suite meters.
// Holds the FSM state type and the default window counter width.
package pvt_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PVT_DEF_WIN_WIDTH = 12;

endpackage

// File: rtl/pvt_token_ring.sv
// Token ring of preserved flops joined by NAND buffer pairs.
// Load injects a one-hot token at bit 0; shift_en advances it one stage.
module pvt_token_ring
    import pvt_meter_pkg::*;
#(
    parameter int N_STAGES = 16,
    parameter int N_BUF    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                shift_en,
    output logic [N_STAGES-1:0] ring
);

    (* keep = "true", dont_touch = "true" *)
    logic [N_STAGES-1:0] r_q;
    logic [N_STAGES-1:1] w_buf;

    genvar gi, gj;
    generate
        for (gi = 1; gi < N_STAGES; gi++) begin : g_stage
            (* keep = "true", dont_touch = "true" *)
            logic [2*N_BUF:0] w_ch;
            assign w_ch[0] = r_q[gi-1];
            for (gj = 0; gj < 2*N_BUF; gj++) begin : g_nand
                assign w_ch[gj+1] = ~(w_ch[gj] & w_ch[gj]);
            end
            assign w_buf[gi] = w_ch[2*N_BUF];
        end
    endgenerate

    // Ring register: inject on load, rotate through the buffers on shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= {{(N_STAGES-1){1'b0}}, 1'b1};
        end else if (shift_en) begin
            r_q <= {w_buf, r_q[N_STAGES-1]};
        end
    end

    assign ring = r_q;

endmodule

// File: rtl/pvt_chain_meter.sv
// Token-ring delay-chain meter: counts laps over a programmed window.
// Optional integrity checker enabled by PVT_CHAIN_METER_CHECK_EN.
module pvt_chain_meter
    import pvt_meter_pkg::*;
#(
    parameter int N_STAGES  = 16,
    parameter int N_BUF     = 1,
    parameter int CNT_WIDTH = 8,
    parameter int WIN_WIDTH = PVT_DEF_WIN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIN_WIDTH-1:0] win_len,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] laps,
    output logic                 err,
    output logic [WIN_WIDTH-1:0] fail_cycle
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_load;
    logic                 w_run;
    logic                 w_last;
    logic [WIN_WIDTH-1:0] w_len_in;
    logic [WIN_WIDTH-1:0] r_len;
    logic [WIN_WIDTH-1:0] r_elapsed;
    logic [CNT_WIDTH-1:0] r_laps;
    logic                 r_done;
    logic [N_STAGES-1:0]  w_ring;

    pvt_token_ring #(
        .N_STAGES (N_STAGES),
        .N_BUF    (N_BUF)
    ) u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .shift_en (w_run),
        .ring     (w_ring)
    );

    assign w_len_in = (win_len == '0) ? {{(WIN_WIDTH-1){1'b0}}, 1'b1}
                                      : win_len;
    assign w_last   = (r_elapsed == r_len - 1'b1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and run/load strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_run       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Window, elapsed and saturating lap counters plus done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_elapsed <= '0;
            r_laps    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_run && w_last;
            if (w_load) begin
                r_len     <= w_len_in;
                r_elapsed <= '0;
                r_laps    <= '0;
            end else if (w_run) begin
                r_elapsed <= r_elapsed + 1'b1;
                if (w_ring[N_STAGES-1] && (r_laps != {CNT_WIDTH{1'b1}})) begin
                    r_laps <= r_laps + 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign laps = r_laps;

`ifdef PVT_CHAIN_METER_CHECK_EN
    logic                 w_onehot;
    logic                 r_err;
    logic [WIN_WIDTH-1:0] r_fail;

    assign w_onehot = (w_ring != '0) &&
                      ((w_ring & (w_ring - 1'b1)) == '0);

    // Sticky token-integrity flag with cycle of first failure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= 1'b0;
            r_fail <= '0;
        end else if (w_load) begin
            r_err  <= 1'b0;
            r_fail <= '0;
        end else if (w_run && !w_onehot && !r_err) begin
            r_err  <= 1'b1;
            r_fail <= r_elapsed;
        end
    end

    assign err        = r_err;
    assign fail_cycle = r_fail;
`else
    logic w_unused_ring;

    assign w_unused_ring = ^w_ring[N_STAGES-2:0];
    assign err           = 1'b0;
    assign fail_cycle    = '0;
`endif

endmodule
